// File: rtl/mpi_bus_sequencer_pkg.sv
// Shared definitions for the MPI register-port bus master: widths, FSM states,
// bus idle levels and a small sizing helper.
package mpi_bus_sequencer_pkg;

  localparam int AW_DEF   = 6;
  localparam int DW_DEF   = 8;
  localparam int NUM_REGS = 48;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_TURN
  } state_t;

  localparam logic IDLE_CS_N = 1'b1;
  localparam logic IDLE_RW   = 1'b1;
  localparam logic IDLE_OE   = 1'b0;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/mpi_bus_sequencer_if.sv
// Requester-side and MPI pad-side signals of the bus sequencer. The master view is
// the sequencer itself; the slave view is the requesters plus the MPI bus/pads.
interface mpi_bus_sequencer_if
  import mpi_bus_sequencer_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);

  logic [1:0]    req;
  logic [1:0]    wr;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic [1:0]    ack;
  logic [DW-1:0] rdata;

  logic [AW-1:0] mpi_addr;
  logic          mpi_cs_n;
  logic          mpi_rw;
  logic          mpi_oe;
  logic [DW-1:0] mpi_wdata;
  logic [DW-1:0] mpi_rdata;

  modport master (
    input  req, wr, addr0, addr1, wdata0, wdata1, mpi_rdata,
    output ack, rdata, mpi_addr, mpi_cs_n, mpi_rw, mpi_oe, mpi_wdata
  );

  modport slave (
    output req, wr, addr0, addr1, wdata0, wdata1, mpi_rdata,
    input  ack, rdata, mpi_addr, mpi_cs_n, mpi_rw, mpi_oe, mpi_wdata
  );

endinterface

// File: rtl/mpi_bus_sequencer_rr_arbiter.sv
// Two-way round-robin arbiter: one-hot grant, pointer moves only when the grant
// is actually taken (advance).
module mpi_rr_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic last_one;  // requester 1 was the last one served

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    gnt = 2'b00;
    if (req[0] && (!req[1] || last_one)) gnt[0] = 1'b1;
    else if (req[1])                      gnt[1] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          last_one <= 1'b1;
    else if (advance) last_one <= gnt[1];
  end

endmodule

// File: rtl/mpi_bus_sequencer.sv
// MPI register-port bus master: arbitrates two single-word requesters and runs each
// access through setup/strobe/hold/turnaround with all bus outputs registered.
module mpi_bus_sequencer
  import mpi_bus_sequencer_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter int SETUP_CYC  = 2,
  parameter int STROBE_CYC = 5,
  parameter int HOLD_CYC   = 1,
  parameter int TURN_CYC   = 2
) (
  input logic                clk,
  input logic                rst,
  mpi_bus_sequencer_if.master bus
);

  localparam int MAX_CYC = max4(SETUP_CYC, STROBE_CYC, HOLD_CYC, TURN_CYC);
  localparam int CW      = $clog2(MAX_CYC + 1);

  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t SETUP_LD  = cnt_t'(SETUP_CYC - 1);
  localparam cnt_t STROBE_LD = cnt_t'(STROBE_CYC - 1);
  localparam cnt_t HOLD_LD   = cnt_t'(HOLD_CYC - 1);
  localparam cnt_t TURN_LD   = cnt_t'(TURN_CYC - 1);

  state_t        state, state_nxt;
  cnt_t          cnt, cnt_nxt;
  logic [1:0]    eff_req;
  logic [1:0]    gnt;
  logic          advance;

  logic [1:0]    gnt_q;
  logic          lat_wr;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_wdata;

  // A requester whose Ack is high this cycle is not eligible on this edge.
  assign eff_req = bus.req & ~bus.ack;

  mpi_rr_arbiter u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (eff_req),
    .advance (advance),
    .gnt     (gnt)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = (cnt == '0) ? '0 : cnt - cnt_t'(1);
    advance   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (|eff_req) begin
          advance   = 1'b1;
          state_nxt = ST_SETUP;
          cnt_nxt   = SETUP_LD;
        end
      end
      ST_SETUP: if (cnt == '0) begin
        state_nxt = ST_STROBE;
        cnt_nxt   = STROBE_LD;
      end
      ST_STROBE: if (cnt == '0) begin
        state_nxt = ST_HOLD;
        cnt_nxt   = HOLD_LD;
      end
      ST_HOLD: if (cnt == '0) begin
        state_nxt = ST_TURN;
        cnt_nxt   = TURN_LD;
      end
      ST_TURN: if (cnt == '0) begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, independent of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // NOTE: the latched request payload is reset too, so an aborted access can never
  // leave X-derived values to reach the pads on the next setup.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_q     <= 2'b00;
      lat_wr    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (advance) begin
      gnt_q     <= gnt;
      lat_wr    <= gnt[1] ? bus.wr[1]  : bus.wr[0];
      lat_addr  <= gnt[1] ? bus.addr1  : bus.addr0;
      lat_wdata <= gnt[1] ? bus.wdata1 : bus.wdata0;
    end
  end

  // Bus outputs are registered from the current state, so they trail the FSM by one
  // cycle; this gives the Ack latency of SETUP+STROBE+HOLD+1 from the grant edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.mpi_addr  <= '0;
      bus.mpi_cs_n  <= IDLE_CS_N;
      bus.mpi_rw    <= IDLE_RW;
      bus.mpi_oe    <= IDLE_OE;
      bus.mpi_wdata <= '0;
      bus.ack       <= 2'b00;
      bus.rdata     <= '0;
    end else begin
      bus.ack <= 2'b00;
      unique case (state)
        ST_SETUP: begin
          bus.mpi_addr <= lat_addr;
          bus.mpi_rw   <= ~lat_wr;
          bus.mpi_oe   <= lat_wr;
          bus.mpi_cs_n <= 1'b1;
          if (lat_wr) bus.mpi_wdata <= lat_wdata;
        end
        ST_STROBE: bus.mpi_cs_n <= 1'b0;
        ST_HOLD: begin
          bus.mpi_cs_n <= 1'b1;
          // First HOLD cycle: the edge that ends the registered strobe window.
          if (!lat_wr && cnt == HOLD_LD) bus.rdata <= bus.mpi_rdata;
        end
        ST_TURN: begin
          bus.mpi_addr <= '0;
          bus.mpi_cs_n <= IDLE_CS_N;
          bus.mpi_rw   <= IDLE_RW;
          bus.mpi_oe   <= IDLE_OE;
          if (cnt == TURN_LD) bus.ack <= gnt_q;
        end
        default: begin
          bus.mpi_addr <= '0;
          bus.mpi_cs_n <= IDLE_CS_N;
          bus.mpi_rw   <= IDLE_RW;
          bus.mpi_oe   <= IDLE_OE;
        end
      endcase
    end
  end

endmodule
